// File: rtl/servo_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : servo_decoder
//  Purpose  : Measures the high time of a servo-style PWM pulse in ticks
//             (1 tick = CLK_DIV clocks) and recovers the 10-bit position.
//             Reports a new-sample strobe, validity, overflow and
//             signal-lost flags.
//  Revision : 1.0  initial release
// ============================================================================
module servo_decoder #(
    parameter int CLK_DIV       = 31,    // clocks per tick, 4..127
    parameter int TIMEOUT_TICKS = 8192   // ticks without a rise before "lost"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [9:0] pos,
    output logic       strobe,
    output logic       valid,
    output logic       overflow,
    output logic       lost
);

    localparam logic [6:0]  c_PRE_MAX  = 7'(CLK_DIV - 1);
    localparam logic [6:0]  c_PRE_HALF = 7'(CLK_DIV / 2);
    localparam logic [13:0] c_TMO      = 14'(TIMEOUT_TICKS);
    localparam logic [13:0] c_TMO_LAST = 14'(TIMEOUT_TICKS - 1);
    localparam logic [9:0]  c_POS_MAX  = 10'h3FF;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1, r_sync2, r_sync_d;
    logic [6:0]  r_pre;
    logic [9:0]  r_width;
    logic        r_ovf;
    logic [9:0]  r_res;
    logic        r_res_ovf;
    logic [6:0]  r_tpre;
    logic [13:0] r_tmo;
    logic [9:0]  r_pos;
    logic        r_strobe, r_valid, r_overflow, r_lost;

    logic        w_rise, w_fall, w_round, w_start, w_capture, w_tick_end, w_timeout;
    logic [10:0] w_sum;
    logic [9:0]  w_result;
    logic        w_result_ovf;

    assign w_rise       = r_sync2 & ~r_sync_d;
    assign w_fall       = ~r_sync2 & r_sync_d;
    // Round to nearest tick: a partial tick of at least half a tick counts.
    assign w_round      = (r_pre >= c_PRE_HALF);
    assign w_sum        = {1'b0, r_width} + {10'd0, w_round};
    assign w_result     = w_sum[10] ? c_POS_MAX : w_sum[9:0];
    assign w_result_ovf = r_ovf | w_sum[10];
    // A rise in REPORT is still honoured so a very short low gap is not lost.
    assign w_start      = w_rise && (r_state == ST_LOW || r_state == ST_REPORT);
    assign w_capture    = (r_state == ST_HIGH) && w_fall && (w_result != 10'd0);
    assign w_tick_end   = (r_tpre == c_PRE_MAX);
    assign w_timeout    = w_tick_end && (r_tmo == c_TMO_LAST);

    // Synchronizer plus edge-detect delay register; no reset so a pulse held
    // high across reset release never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        r_sync1  <= in;
        r_sync2  <= r_sync1;
        r_sync_d <= r_sync2;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_ARM;
        else       r_state <= w_next;
    end

    // Next-state logic; a zero-tick result is a glitch and goes straight to LOW.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARM:    if (!r_sync2) w_next = ST_LOW;
            ST_LOW:    if (w_rise)   w_next = ST_HIGH;
            ST_HIGH:   if (w_fall)   w_next = (w_result != 10'd0) ? ST_REPORT : ST_LOW;
            ST_REPORT: w_next = w_rise ? ST_HIGH : ST_LOW;
            default:   w_next = ST_ARM;
        endcase
    end

    // Pulse-width measurement in ticks, saturating at 1023 with overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre     <= '0;
            r_width   <= '0;
            r_ovf     <= 1'b0;
            r_res     <= '0;
            r_res_ovf <= 1'b0;
        end else begin
            if (w_start) begin
                r_pre   <= '0;
                r_width <= '0;
                r_ovf   <= 1'b0;
            end else if (r_state == ST_HIGH && !w_fall) begin
                if (r_pre == c_PRE_MAX) begin
                    r_pre <= '0;
                    if (r_width == c_POS_MAX) r_ovf <= 1'b1;
                    else                      r_width <= r_width + 10'd1;
                end else begin
                    r_pre <= r_pre + 7'd1;
                end
            end
            if (w_capture) begin
                r_res     <= w_result;
                r_res_ovf <= w_result_ovf;
            end
        end
    end

    // Ticks since the last rising edge; saturates at the timeout value.
    always_ff @(posedge clk) begin
        if (reset || w_rise) begin
            r_tpre <= '0;
            r_tmo  <= '0;
        end else if (w_tick_end) begin
            r_tpre <= '0;
            if (r_tmo != c_TMO) r_tmo <= r_tmo + 14'd1;
        end else begin
            r_tpre <= r_tpre + 7'd1;
        end
    end

    // Output registers; a measurement in flight takes priority over a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos      <= '0;
            r_strobe   <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_state == ST_REPORT) begin
                r_pos      <= r_res;
                r_overflow <= r_res_ovf;
                r_strobe   <= 1'b1;
                r_valid    <= ~r_res_ovf;
                r_lost     <= 1'b0;
            end else if (w_timeout && !w_capture) begin
                r_lost  <= 1'b1;
                r_valid <= 1'b0;
            end
        end
    end

    assign pos      = r_pos;
    assign strobe   = r_strobe;
    assign valid    = r_valid;
    assign overflow = r_overflow;
    assign lost     = r_lost;

endmodule
`default_nettype wire
